// File: rtl/nes_bus_pkg.sv
// Shared constants and bus payload type for the NES CPU-bus arbiter.
package nes_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_HALT    = 3'd1;
  localparam logic [ST_W-1:0] ST_ALIGN   = 3'd2;
  localparam logic [ST_W-1:0] ST_GRANT   = 3'd3;
  localparam logic [ST_W-1:0] ST_RELEASE = 3'd4;

  // One master's drive onto the shared bus
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wn;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/nes_bus_arbiter.sv
// CPU-domain arbiter between the 6502 core and sprite DMA: halts the CPU via RDY,
// aligns to the get/put parity, grants the bus, and enforces a grant watchdog.
module nes_bus_arbiter
  import nes_bus_pkg::*;
#(
  parameter int unsigned P_MAX_GNT = 1024,
  parameter int unsigned P_CNT_W   = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_wn,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rdy,
  input  logic              i_spr_req,
  output logic              o_spr_gnt,
  input  logic [ADDR_W-1:0] i_spr_addr,
  input  logic              i_spr_wn,
  input  logic [DATA_W-1:0] i_spr_wdata,
  output logic [DATA_W-1:0] o_spr_rdata,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_wn,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_gnt_err
);

  localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_MAX_GNT - 1);

  logic [ST_W-1:0]    state;
  logic [ST_W-1:0]    state_nxt;
  logic               parity;
  logic [P_CNT_W-1:0] gnt_cnt;
  logic               gnt_err;
  logic               wdog_hit;
  logic               cpu_rdy;
  logic               spr_gnt;
  bus_req_t           cpu_req;
  bus_req_t           spr_req;
  bus_req_t           bus_req;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Get/put parity, grant-length counter and sticky watchdog error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parity  <= 1'b0;
      gnt_cnt <= '0;
      gnt_err <= 1'b0;
    end else begin
      parity <= ~parity;
      if (state == ST_GRANT) begin
        gnt_cnt <= gnt_cnt + P_CNT_W'(1);
      end else begin
        gnt_cnt <= '0;
      end
      if (wdog_hit) begin
        gnt_err <= 1'b1;
      end
    end
  end

  // Next-state logic; the 6502 ignores RDY on writes, so HALT waits for a read cycle
  always_comb begin
    state_nxt = state;
    wdog_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_spr_req) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!i_spr_req) begin
          state_nxt = ST_RELEASE;
        end else if (i_cpu_wn) begin
          state_nxt = parity ? ST_GRANT : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (!i_spr_req) begin
          state_nxt = ST_RELEASE;
        end else if (gnt_cnt == CNT_LAST) begin
          state_nxt = ST_RELEASE;
          wdog_hit  = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register
  always_comb begin
    cpu_rdy = 1'b0;
    spr_gnt = 1'b0;
    case (state)
      ST_IDLE:  cpu_rdy = 1'b1;
      ST_GRANT: spr_gnt = 1'b1;
      default:  ;
    endcase
  end

  // Bus mux: DMA drives only while granted
  assign cpu_req = {i_cpu_addr, i_cpu_wn, i_cpu_wdata};
  assign spr_req = {i_spr_addr, i_spr_wn, i_spr_wdata};
  assign bus_req = spr_gnt ? spr_req : cpu_req;

  assign o_bus_addr  = bus_req.addr;
  assign o_bus_wn    = bus_req.wn;
  assign o_bus_wdata = bus_req.wdata;
  assign o_cpu_rdata = i_bus_rdata;
  assign o_spr_rdata = i_bus_rdata;
  assign o_cpu_rdy   = cpu_rdy;
  assign o_spr_gnt   = spr_gnt;
  assign o_gnt_err   = gnt_err;

endmodule

// File: tb/tb_nes_bus_arbiter.sv
// Scoreboard bench for nes_bus_arbiter: directed per-cycle expectations are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_nes_bus_arbiter;

  typedef struct packed {
    int unsigned cyc;
    logic        rdy;
    logic        gnt;
    logic        err;
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  wdata;
    logic [7:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_wn;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        gnt_err;

  exp_t        sb[$];
  int          n_run = 0;
  int          n_fail = 0;
  int unsigned cycnum = 0;
  logic        par = 1'b0;
  logic        exp_err = 1'b0;
  logic        auto_vary = 1'b1;

  nes_bus_arbiter #(
    .P_MAX_GNT(1024),
    .P_CNT_W  (11)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cpu_addr (cpu_addr),
    .i_cpu_wn   (cpu_wn),
    .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata),
    .o_cpu_rdy  (cpu_rdy),
    .i_spr_req  (spr_req),
    .o_spr_gnt  (spr_gnt),
    .i_spr_addr (spr_addr),
    .i_spr_wn   (spr_wn),
    .i_spr_wdata(spr_wdata),
    .o_spr_rdata(spr_rdata),
    .o_bus_addr (bus_addr),
    .o_bus_wn   (bus_wn),
    .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata),
    .o_gnt_err  (gnt_err)
  );

  always #5 clk = ~clk;

  // Queue this cycle's expected outputs, then advance one clock
  task automatic tick(input logic rdy, input logic gnt);
    exp_t e;
    if (auto_vary) begin
      cpu_addr  = 16'h8000 ^ 16'(cycnum * 37);
      cpu_wdata = 8'(cycnum * 3 + 1);
      spr_addr  = 16'h0200 + 16'(cycnum);
      spr_wdata = 8'(cycnum) ^ 8'h96;
      bus_rdata = 8'(cycnum * 7 + 5);
    end
    e.cyc   = cycnum;
    e.rdy   = rdy;
    e.gnt   = gnt;
    e.err   = exp_err;
    e.addr  = gnt ? spr_addr  : cpu_addr;
    e.wn    = gnt ? spr_wn    : cpu_wn;
    e.wdata = gnt ? spr_wdata : cpu_wdata;
    e.rd    = bus_rdata;
    sb.push_back(e);
    @(posedge clk);
    par = rst ? 1'b0 : ~par;
    #1;
    cycnum++;
  endtask

  // One DMA transaction; hp is the parity of the HALT cycle that sees a CPU read
  task automatic grant_seq(input logic hp, input int n_wr, input int n_gnt, input logic drop);
    logic pt;
    pt      = hp ^ 1'((n_wr + 1) & 1);
    spr_req = 1'b0;
    cpu_wn  = 1'b1;
    while (par != pt) tick(1'b1, 1'b0);
    spr_req = 1'b1;
    cpu_wn  = (n_wr > 0) ? 1'b0 : 1'b1;
    tick(1'b1, 1'b0);
    for (int i = 0; i < n_wr; i++) begin
      cpu_wn = 1'b0;
      tick(1'b0, 1'b0);
    end
    cpu_wn = 1'b1;
    tick(1'b0, 1'b0);
    if (!hp) tick(1'b0, 1'b0);
    for (int g = 1; g <= n_gnt; g++) begin
      spr_req = drop ? (g < n_gnt) : 1'b1;
      tick(1'b0, 1'b1);
    end
    if (drop) begin
      spr_req = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end
  endtask

  // Monitor: one popped expectation per cycle, compared on the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_run++;
      if ({cpu_rdy, spr_gnt, gnt_err, bus_addr, bus_wn, bus_wdata, cpu_rdata, spr_rdata} !==
          {e.rdy, e.gnt, e.err, e.addr, e.wn, e.wdata, e.rd, e.rd}) begin
        n_fail++;
        $display("FAIL cyc%0d: got rdy=%b gnt=%b err=%b addr=%h wn=%b wd=%h crd=%h srd=%h, want rdy=%b gnt=%b err=%b addr=%h wn=%b wd=%h rd=%h",
                 e.cyc, cpu_rdy, spr_gnt, gnt_err, bus_addr, bus_wn, bus_wdata, cpu_rdata, spr_rdata,
                 e.rdy, e.gnt, e.err, e.addr, e.wn, e.wdata, e.rd);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    spr_req   = 1'b0;
    cpu_wn    = 1'b1;
    spr_wn    = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    spr_addr  = '0;
    spr_wdata = '0;
    bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    par = 1'b0;
    tick(1'b1, 1'b0);
    rst = 1'b0;

    // Parity-odd halt then 512-cycle grant; parity-even inserts ALIGN
    grant_seq(1'b1, 0, 512, 1'b1);
    grant_seq(1'b0, 0, 512, 1'b1);

    // CPU writes in flight keep the arbiter in HALT
    grant_seq(1'b1, 3, 8, 1'b1);
    grant_seq(1'b0, 2, 8, 1'b1);

    // DMA write onto the bus with fixed values
    auto_vary = 1'b0;
    cpu_addr  = 16'h4016;
    cpu_wdata = 8'h11;
    spr_addr  = 16'h2004;
    spr_wn    = 1'b0;
    spr_wdata = 8'hA5;
    bus_rdata = 8'h3C;
    grant_seq(1'b1, 0, 4, 1'b1);
    auto_vary = 1'b1;
    spr_wn    = 1'b1;

    // Watchdog: request never drops
    grant_seq(1'b1, 0, 1024, 1'b0);
    exp_err = 1'b1;
    cpu_wn  = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    spr_req = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // Reset during grant cycle 100
    grant_seq(1'b0, 0, 99, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b1);
    rst     = 1'b0;
    spr_req = 1'b0;
    exp_err = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    grant_seq(1'b1, 0, 3, 1'b1);

    @(negedge clk);
    #1;
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
